vc_input_port: RTL and testbench
================================

# vc_input_port

Parametrised NoC router input port: one input buffer per virtual channel, with credit-based flow control toward the upstream router. Incoming flits are steered to a per-VC FIFO by `in_vc`, and each VC tracks packet framing with its own head/body/tail state machine. A VC is dequeued only when both routing and switch allocation grant it; each dequeue returns one credit upstream. It sits between the link receiver and the router's route-compute/switch-allocation stages, and replaces the single-buffer, ungated-credit input port.

## Interface
- `FLIT_W`, 32, flit width; bits [FLIT_W-1:FLIT_W-2] are the type field: 00 invalid, 01 head, 10 body, 11 tail
- `NUM_VC`, 2, number of virtual channels (≥2)
- `DEPTH`, 6, flit slots per VC (≥2)
- `VCW`, derived, $clog2(NUM_VC)
- `clk`  in  1  rising-edge clock; one clock domain
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  a flit is present on `in_flit` this cycle
- `in_vc`  in  VCW  target VC of the incoming flit
- `in_flit`  in  FLIT_W  incoming flit
- `route_grant`  in  NUM_VC  per-VC routing-stage grant
- `sw_grant`  in  NUM_VC  per-VC switch-allocation grant
- `out_valid`  out  1  `out_flit` is valid
- `out_vc`  out  VCW  VC that `out_flit` came from
- `out_flit`  out  FLIT_W  dequeued flit
- `credit_out`  out  1  one-cycle credit pulse to upstream
- `credit_vc`  out  VCW  VC the credit belongs to
- `vc_empty`  out  NUM_VC  VC has 0 flits
- `vc_full`  out  NUM_VC  VC holds DEPTH flits
- `vc_head_at_front`  out  NUM_VC  front flit of the VC is a head flit (route request)
- `err_overflow`  out  1  sticky: a write to a full VC was dropped
- `err_protocol`  out  1  sticky: a framing violation was dropped

## Operation
- Each VC has a circular FIFO with read/write pointers that wrap at DEPTH, and a count of width $clog2(DEPTH+1).
- Write acceptance: a flit is written when `in_valid`=1 and its type≠00, the framing check passes, and either count<DEPTH or the same VC is dequeued in the same cycle.
  - A flit with type 00 is ignored and raises no error.
- Framing FSM per VC, advanced on each accepted write:
  - IDLE accepts only a head and moves to ACTIVE.
  - ACTIVE accepts body (stays ACTIVE) or tail (returns to IDLE).
  - Body or tail in IDLE, or head in ACTIVE: flit dropped, `err_protocol` set, state unchanged.
- Full-VC write that is not covered by a same-cycle dequeue: dropped and `err_overflow` set. The framing FSM does not advance.
- Dequeue eligibility: VC v is eligible when `route_grant[v] & sw_grant[v]` and count_v>0, using the count before this cycle's write.
  - An empty VC is never dequeued by a same-cycle write; there is no bypass path.
- At most one dequeue per cycle. If several VCs are eligible, the lowest index wins.
- A simultaneous write and read on the same VC leaves the count unchanged, including at full.
- Status outputs (`vc_empty`, `vc_full`, `vc_head_at_front`) are decoded from registered state and reflect end-of-cycle contents.

## Timing
- Reset (async assert; release synchronised by the integrator):
  - All counts and pointers go to 0 and every FSM to IDLE.
  - `out_valid`, `out_vc`, `out_flit`, `credit_out`, `credit_vc`, `vc_head_at_front`, `err_overflow` and `err_protocol` go to 0.
  - `vc_empty` goes to all-1s and `vc_full` to 0.
  - Reset mid-packet discards all buffered flits; no credits are issued for them.
- Write latency: a flit accepted at edge N is visible in status from N+1, and is dequeueable by grants sampled at edge N+1.
- Dequeue at edge N: `out_valid`, `out_vc` and `out_flit` are registered and valid for exactly the cycle after N. `credit_out`=1 with `credit_vc`=VC in that same cycle.
- With no dequeue, `out_valid` and `credit_out` are 0. `out_flit` holds its last value.
- Sustained throughput: one flit per cycle in, and one flit per cycle out.
- `err_overflow` and `err_protocol` clear only on reset.

## Test plan
- Reset, then head, body, tail to VC0 on three cycles; grants held on VC0 → `out_flit` emits the 3 flits in order from cycle 2; 3 `credit_out` pulses with `credit_vc`=0; `vc_empty`=2'b11 at the end.
- Fill VC1 with 6 flits (head plus 5 body), no grants → `vc_full`=2'b10. A 7th body flit sets `err_overflow`=1 and the count stays 6. The next cycle, a write plus a VC1 grant is accepted with the count staying at 6.
- Body flit to an IDLE VC0 → `err_protocol`=1, `vc_empty[0]`=1. A head flit to ACTIVE VC1 → dropped, VC1 count unchanged.
- Both VCs non-empty with both granted → VC0 is dequeued, `out_vc`=0. The next cycle, with only VC1 granted → `out_vc`=1.
- Write to empty VC0 with its grant high in the same cycle → no dequeue that cycle; flit emitted one cycle later.
- Assert `rst_n`=0 asynchronously mid-packet with 4 flits buffered → all outputs reach their reset values before the next edge. After release, a new head to VC0 is accepted.

Source files
------------

// File: rtl/vc_input_port.sv
// vc_input_port: per-VC input buffers with framing check, lowest-index dequeue and credit return
module vc_input_port #(
  parameter int FLIT_W = 32,
  parameter int NUM_VC = 2,
  parameter int DEPTH  = 6,
  parameter int VCW    = $clog2(NUM_VC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [VCW-1:0]    in_vc,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic [NUM_VC-1:0] route_grant,
  input  logic [NUM_VC-1:0] sw_grant,
  output logic              out_valid,
  output logic [VCW-1:0]    out_vc,
  output logic [FLIT_W-1:0] out_flit,
  output logic              credit_out,
  output logic [VCW-1:0]    credit_vc,
  output logic [NUM_VC-1:0] vc_empty,
  output logic [NUM_VC-1:0] vc_full,
  output logic [NUM_VC-1:0] vc_head_at_front,
  output logic              err_overflow,
  output logic              err_protocol
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t            state [NUM_VC];
  state_t            state_nxt [NUM_VC];
  logic [FLIT_W-1:0] mem [NUM_VC][DEPTH];
  logic [PW-1:0]     rd_ptr [NUM_VC];
  logic [PW-1:0]     wr_ptr [NUM_VC];
  logic [CW-1:0]     cnt [NUM_VC];
  logic [1:0]        typ;
  logic [NUM_VC-1:0] elig, deq_sel, wr;
  logic [VCW-1:0]    deq_vc;
  logic              deq, perr, oerr, hit, ok, space;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign typ = in_flit[FLIT_W-1 -: 2];

  always_comb begin
    elig = '0;
    for (int v = 0; v < NUM_VC; v++)
      elig[v] = route_grant[v] & sw_grant[v] & (cnt[v] != '0);
    deq_sel = elig & -elig;
    deq = |elig;
    deq_vc = '0;
    for (int v = NUM_VC - 1; v >= 0; v--)
      if (elig[v]) deq_vc = VCW'(v);
    wr = '0;
    perr = 1'b0;
    oerr = 1'b0;
    hit = 1'b0;
    ok = 1'b0;
    space = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      hit = in_valid && typ != 2'b00 && in_vc == VCW'(v);
      ok = state[v] == IDLE ? typ == 2'b01 : typ[1];
      space = cnt[v] != CW'(DEPTH) || deq_sel[v];
      wr[v] = hit && ok && space;
      perr = perr | (hit && !ok);
      oerr = oerr | (hit && ok && !space);
      state_nxt[v] = wr[v] ? (typ == 2'b11 ? IDLE : ACTIVE) : state[v];
      vc_empty[v] = cnt[v] == '0;
      vc_full[v] = cnt[v] == CW'(DEPTH);
      vc_head_at_front[v] = cnt[v] != '0 && mem[v][rd_ptr[v]][FLIT_W-1 -: 2] == 2'b01;
    end
  end

  always_ff @(posedge clk)
    for (int v = 0; v < NUM_VC; v++)
      if (wr[v]) mem[v][wr_ptr[v]] <= in_flit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        state[v] <= IDLE;
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        cnt[v] <= '0;
      end
      out_valid <= 1'b0;
      out_vc <= '0;
      out_flit <= '0;
      credit_out <= 1'b0;
      credit_vc <= '0;
      err_overflow <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        state[v] <= state_nxt[v];
        rd_ptr[v] <= deq_sel[v] ? nxt(rd_ptr[v]) : rd_ptr[v];
        wr_ptr[v] <= wr[v] ? nxt(wr_ptr[v]) : wr_ptr[v];
        cnt[v] <= cnt[v] + CW'(wr[v]) - CW'(deq_sel[v]);
      end
      out_valid <= deq;
      credit_out <= deq;
      out_vc <= deq ? deq_vc : out_vc;
      credit_vc <= deq ? deq_vc : credit_vc;
      out_flit <= deq ? mem[deq_vc][rd_ptr[deq_vc]] : out_flit;
      err_overflow <= err_overflow | oerr;
      err_protocol <= err_protocol | perr;
    end
  end
endmodule

// File: tb/tb_vc_input_port.sv
// tb_vc_input_port: directed self-checking bench for vc_input_port
module tb_vc_input_port;
  localparam logic [31:0] H = 32'h4000_0000;
  localparam logic [31:0] B = 32'h8000_0000;
  localparam logic [31:0] T = 32'hC000_0000;
  logic        clk, rst_n, in_valid, in_vc;
  logic [31:0] in_flit, out_flit;
  logic [1:0]  route_grant, sw_grant, vc_empty, vc_full, vc_head_at_front;
  logic        out_valid, out_vc, credit_out, credit_vc, err_overflow, err_protocol;
  int tests = 0;
  int failed = 0;

  vc_input_port dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
    .route_grant(route_grant), .sw_grant(sw_grant), .out_valid(out_valid), .out_vc(out_vc),
    .out_flit(out_flit), .credit_out(credit_out), .credit_vc(credit_vc), .vc_empty(vc_empty),
    .vc_full(vc_full), .vc_head_at_front(vc_head_at_front), .err_overflow(err_overflow),
    .err_protocol(err_protocol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic vc, input logic [31:0] f, input logic [1:0] g);
    in_valid = v;
    in_vc = vc;
    in_flit = f;
    route_grant = g;
    sw_grant = g;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    drive(0, 0, 0, 2'b00);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    tests++; if (credit_out !== 1'b0) begin failed++; $display("FAIL reset_credit_out: got %b exp 0", credit_out); end
    tests++; if (out_flit !== 32'h0) begin failed++; $display("FAIL reset_out_flit: got %h exp 0", out_flit); end
    tests++; if (vc_empty !== 2'b11) begin failed++; $display("FAIL reset_vc_empty: got %b exp 11", vc_empty); end
    tests++; if (vc_full !== 2'b00) begin failed++; $display("FAIL reset_vc_full: got %b exp 00", vc_full); end
    tests++; if (vc_head_at_front !== 2'b00) begin failed++; $display("FAIL reset_head: got %b exp 00", vc_head_at_front); end
    tests++; if ({err_overflow, err_protocol} !== 2'b00) begin failed++; $display("FAIL reset_errs: got %b exp 00", {err_overflow, err_protocol}); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_basic;
    drive(1, 0, H | 32'd1, 2'b01);
    tick;
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL basic_no_early_out: got %b exp 0", out_valid); end
    tests++; if (vc_head_at_front !== 2'b01) begin failed++; $display("FAIL basic_head_front: got %b exp 01", vc_head_at_front); end
    tests++; if (vc_empty !== 2'b10) begin failed++; $display("FAIL basic_empty1: got %b exp 10", vc_empty); end
    drive(1, 0, B | 32'd2, 2'b01);
    tick;
    tests++; if ({out_valid, out_flit} !== {1'b1, H | 32'd1}) begin failed++; $display("FAIL basic_out_head: got %b/%h exp 1/%h", out_valid, out_flit, H | 32'd1); end
    tests++; if ({credit_out, credit_vc} !== 2'b10) begin failed++; $display("FAIL basic_credit1: got %b%b exp 10", credit_out, credit_vc); end
    drive(1, 0, T | 32'd3, 2'b01);
    tick;
    tests++; if ({out_valid, out_flit} !== {1'b1, B | 32'd2}) begin failed++; $display("FAIL basic_out_body: got %b/%h exp 1/%h", out_valid, out_flit, B | 32'd2); end
    tests++; if ({credit_out, credit_vc} !== 2'b10) begin failed++; $display("FAIL basic_credit2: got %b%b exp 10", credit_out, credit_vc); end
    drive(0, 0, 0, 2'b01);
    tick;
    tests++; if ({out_valid, out_vc, out_flit} !== {2'b10, T | 32'd3}) begin failed++; $display("FAIL basic_out_tail: got %b/%b/%h exp 1/0/%h", out_valid, out_vc, out_flit, T | 32'd3); end
    tests++; if ({credit_out, credit_vc} !== 2'b10) begin failed++; $display("FAIL basic_credit3: got %b%b exp 10", credit_out, credit_vc); end
    tests++; if (vc_empty !== 2'b11) begin failed++; $display("FAIL basic_empty_end: got %b exp 11", vc_empty); end
    drive(0, 0, 0, 2'b00);
    tick;
    tests++; if ({out_valid, credit_out} !== 2'b00) begin failed++; $display("FAIL basic_idle: got %b%b exp 00", out_valid, credit_out); end
    tests++; if (out_flit !== (T | 32'd3)) begin failed++; $display("FAIL basic_flit_hold: got %h exp %h", out_flit, T | 32'd3); end
  endtask

  task automatic test_overflow;
    logic [31:0] exp_q [6];
    exp_q = '{B | 32'd11, B | 32'd12, B | 32'd13, B | 32'd14, B | 32'd15, B | 32'd17};
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, i == 0 ? H | 32'd10 : B | (32'd10 + 32'(i)), 2'b00);
      tick;
    end
    tests++; if (vc_full !== 2'b10) begin failed++; $display("FAIL ovf_full: got %b exp 10", vc_full); end
    tests++; if (vc_empty !== 2'b01) begin failed++; $display("FAIL ovf_empty: got %b exp 01", vc_empty); end
    tests++; if (err_overflow !== 1'b0) begin failed++; $display("FAIL ovf_not_yet: got %b exp 0", err_overflow); end
    drive(1, 1, B | 32'd16, 2'b00);
    tick;
    tests++; if (err_overflow !== 1'b1) begin failed++; $display("FAIL ovf_flag: got %b exp 1", err_overflow); end
    tests++; if (vc_full !== 2'b10) begin failed++; $display("FAIL ovf_still_full: got %b exp 10", vc_full); end
    drive(1, 1, B | 32'd17, 2'b10);
    tick;
    tests++; if ({out_valid, out_vc, out_flit} !== {2'b11, H | 32'd10}) begin failed++; $display("FAIL ovf_deq_head: got %b/%b/%h exp 1/1/%h", out_valid, out_vc, out_flit, H | 32'd10); end
    tests++; if (vc_full !== 2'b10) begin failed++; $display("FAIL ovf_full_rw: got %b exp 10", vc_full); end
    drive(0, 0, 0, 2'b10);
    for (int i = 0; i < 6; i++) begin
      tick;
      tests++; if ({out_valid, out_flit} !== {1'b1, exp_q[i]}) begin failed++; $display("FAIL ovf_drain%0d: got %b/%h exp 1/%h", i, out_valid, out_flit, exp_q[i]); end
    end
    tests++; if (vc_empty !== 2'b11) begin failed++; $display("FAIL ovf_drained: got %b exp 11", vc_empty); end
    tests++; if (err_overflow !== 1'b1) begin failed++; $display("FAIL ovf_sticky: got %b exp 1", err_overflow); end
    drive(0, 0, 0, 2'b00);
    tick;
  endtask

  task automatic test_protocol;
    tests++; if (err_protocol !== 1'b0) begin failed++; $display("FAIL proto_clean: got %b exp 0", err_protocol); end
    drive(1, 0, B | 32'd20, 2'b00);
    tick;
    tests++; if (err_protocol !== 1'b1) begin failed++; $display("FAIL proto_flag: got %b exp 1", err_protocol); end
    tests++; if (vc_empty !== 2'b11) begin failed++; $display("FAIL proto_vc0_empty: got %b exp 11", vc_empty); end
    drive(1, 1, H | 32'd21, 2'b00);
    tick;
    tests++; if (vc_empty !== 2'b11) begin failed++; $display("FAIL proto_vc1_drop: got %b exp 11", vc_empty); end
    drive(1, 1, T | 32'd22, 2'b00);
    tick;
    tests++; if ({vc_empty, vc_head_at_front} !== 4'b0100) begin failed++; $display("FAIL proto_tail_in: got %b/%b exp 01/00", vc_empty, vc_head_at_front); end
    drive(0, 0, 0, 2'b10);
    tick;
    tests++; if ({out_valid, out_flit} !== {1'b1, T | 32'd22}) begin failed++; $display("FAIL proto_tail_out: got %b/%h exp 1/%h", out_valid, out_flit, T | 32'd22); end
    drive(0, 0, 0, 2'b00);
    tick;
  endtask

  task automatic test_priority;
    drive(1, 0, H | 32'd30, 2'b00);
    tick;
    drive(1, 1, H | 32'd31, 2'b00);
    tick;
    tests++; if ({vc_empty, vc_head_at_front} !== 4'b0011) begin failed++; $display("FAIL prio_loaded: got %b/%b exp 00/11", vc_empty, vc_head_at_front); end
    drive(0, 0, 0, 2'b11);
    tick;
    tests++; if ({out_valid, out_vc, out_flit} !== {2'b10, H | 32'd30}) begin failed++; $display("FAIL prio_low_wins: got %b/%b/%h exp 1/0/%h", out_valid, out_vc, out_flit, H | 32'd30); end
    drive(0, 0, 0, 2'b10);
    tick;
    tests++; if ({out_valid, out_vc, out_flit} !== {2'b11, H | 32'd31}) begin failed++; $display("FAIL prio_vc1: got %b/%b/%h exp 1/1/%h", out_valid, out_vc, out_flit, H | 32'd31); end
    tests++; if ({credit_out, credit_vc} !== 2'b11) begin failed++; $display("FAIL prio_credit_vc1: got %b%b exp 11", credit_out, credit_vc); end
    drive(0, 0, 0, 2'b00);
    tick;
  endtask

  task automatic test_no_bypass;
    drive(1, 0, T | 32'd40, 2'b01);
    tick;
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL bypass_none: got %b exp 0", out_valid); end
    drive(0, 0, 0, 2'b01);
    tick;
    tests++; if ({out_valid, out_flit} !== {1'b1, T | 32'd40}) begin failed++; $display("FAIL bypass_late: got %b/%h exp 1/%h", out_valid, out_flit, T | 32'd40); end
    drive(0, 0, 0, 2'b00);
    tick;
  endtask

  task automatic test_reset_mid_packet;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, i == 0 ? H | 32'd50 : B | (32'd50 + 32'(i)), 2'b00);
      tick;
    end
    drive(1, 1, B | 32'd54, 2'b00);
    tick;
    drive(0, 0, 0, 2'b10);
    tick;
    tests++; if ({out_valid, out_vc, out_flit} !== {2'b11, B | 32'd54}) begin failed++; $display("FAIL rst_pre_out: got %b/%b/%h exp 1/1/%h", out_valid, out_vc, out_flit, B | 32'd54); end
    tests++; if (vc_empty !== 2'b10) begin failed++; $display("FAIL rst_pre_empty: got %b exp 10", vc_empty); end
    drive(0, 0, 0, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({out_valid, credit_out} !== 2'b00) begin failed++; $display("FAIL rst_async_valid: got %b%b exp 00", out_valid, credit_out); end
    tests++; if ({out_vc, credit_vc, out_flit} !== 34'h0) begin failed++; $display("FAIL rst_async_data: got %b/%b/%h exp 0/0/0", out_vc, credit_vc, out_flit); end
    tests++; if ({vc_empty, vc_full, vc_head_at_front} !== 6'b110000) begin failed++; $display("FAIL rst_async_status: got %b/%b/%b exp 11/00/00", vc_empty, vc_full, vc_head_at_front); end
    tests++; if ({err_overflow, err_protocol} !== 2'b00) begin failed++; $display("FAIL rst_async_errs: got %b exp 00", {err_overflow, err_protocol}); end
    @(negedge clk) rst_n = 1'b1;
    drive(1, 0, H | 32'd60, 2'b00);
    tick;
    tests++; if ({vc_empty, vc_head_at_front, out_valid} !== 5'b10010) begin failed++; $display("FAIL rst_new_head: got %b/%b/%b exp 10/01/0", vc_empty, vc_head_at_front, out_valid); end
    drive(0, 0, 0, 2'b01);
    tick;
    tests++; if ({out_valid, out_flit} !== {1'b1, H | 32'd60}) begin failed++; $display("FAIL rst_new_out: got %b/%h exp 1/%h", out_valid, out_flit, H | 32'd60); end
    drive(0, 0, 0, 2'b00);
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_protocol;
    test_priority;
    test_no_bypass;
    test_reset_mid_packet;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
